// File: rtl/membus_arbiter_pkg.sv
// Shared bus widths and owner encoding for the memory-bus arbiter slice.
package eei;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef logic [ADDR_WIDTH-1:0] Addr;
  typedef logic [DATA_WIDTH-1:0] Data;
  typedef logic [MASK_WIDTH-1:0] Mask;

  typedef enum logic {
    OWNER_I,
    OWNER_D
  } membus_owner_t;
endpackage

// File: rtl/membus_if.sv
// Valid/ready request channel with a separate rvalid response.
interface membus_if;
  import eei::*;

  logic valid;
  logic ready;
  Addr  addr;
  logic wen;
  Data  wdata;
  Mask  wmask;
  logic rvalid;
  Data  rdata;

  modport master (
    output valid, addr, wen, wdata, wmask,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wen, wdata, wmask,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/membus_rr_arb2.sv
// Two-way grant selection: a held lock wins, otherwise a single valid wins,
// otherwise ties go round-robin or to the data port.
module membus_rr_arb2
  import eei::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic          inst_valid,
  input  logic          data_valid,
  input  membus_owner_t last_grant,
  input  logic          lock,
  input  membus_owner_t lock_grant,
  output membus_owner_t grant
);
  always_comb begin
    grant = OWNER_I;
    if (lock) begin
      grant = lock_grant;
    end else if (inst_valid && data_valid) begin
      if (RR_EN) begin
        grant = (last_grant == OWNER_I) ? OWNER_D : OWNER_I;
      end else begin
        grant = OWNER_D;
      end
    end else if (data_valid) begin
      grant = OWNER_D;
    end
  end
endmodule

// File: rtl/membus_arbiter.sv
// Arbitrates instruction and load/store requesters onto one memory bus,
// allowing a single outstanding transaction and routing the response back.
module membus_arbiter
  import eei::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input logic      clk,
  input logic      rst,
  membus_if.slave  i_membus,
  membus_if.slave  d_membus,
  membus_if.master m_membus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]    state_reg, state_next;
  membus_owner_t owner_reg, owner_next;
  membus_owner_t last_grant_reg, last_grant_next;
  membus_owner_t lock_grant_reg, lock_grant_next;
  logic          lock_reg, lock_next;

  membus_owner_t grant;
  logic          granted_valid;
  logic          in_idle;
  logic          in_wait;
  logic          m_valid;
  logic          handshake;

  membus_rr_arb2 #(
    .RR_EN(RR_EN)
  ) u_arb (
    .inst_valid(i_membus.valid),
    .data_valid(d_membus.valid),
    .last_grant(last_grant_reg),
    .lock      (lock_reg),
    .lock_grant(lock_grant_reg),
    .grant     (grant)
  );

  // Gating with rst keeps every handshake output quiet while reset is held.
  always_comb begin
    in_idle       = (state_reg == IDLE) && rst;
    in_wait       = (state_reg == WAIT);
    granted_valid = (grant == OWNER_D) ? d_membus.valid : i_membus.valid;
    m_valid       = in_idle && granted_valid;
    handshake     = m_valid && m_membus.ready;
  end

  always_comb begin
    m_membus.valid = m_valid;
    m_membus.addr  = '0;
    m_membus.wen   = 1'b0;
    m_membus.wdata = '0;
    m_membus.wmask = '0;
    if (m_valid) begin
      if (grant == OWNER_D) begin
        m_membus.addr  = d_membus.addr;
        m_membus.wen   = d_membus.wen;
        m_membus.wdata = d_membus.wdata;
        m_membus.wmask = d_membus.wmask;
      end else begin
        m_membus.addr  = i_membus.addr;
        m_membus.wen   = i_membus.wen;
        m_membus.wdata = i_membus.wdata;
        m_membus.wmask = i_membus.wmask;
      end
    end

    i_membus.ready = in_idle && (grant == OWNER_I) && m_membus.ready;
    d_membus.ready = in_idle && (grant == OWNER_D) && m_membus.ready;

    i_membus.rvalid = in_wait && (owner_reg == OWNER_I) && m_membus.rvalid;
    d_membus.rvalid = in_wait && (owner_reg == OWNER_D) && m_membus.rvalid;
    i_membus.rdata  = (in_wait && (owner_reg == OWNER_I)) ? m_membus.rdata : '0;
    d_membus.rdata  = (in_wait && (owner_reg == OWNER_D)) ? m_membus.rdata : '0;
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    lock_next       = lock_reg;
    lock_grant_next = lock_grant_reg;
    case (state_reg)
      IDLE: begin
        if (handshake) begin
          state_next      = WAIT;
          owner_next      = grant;
          last_grant_next = grant;
          lock_next       = 1'b0;
        end else begin
          // A stalled request pins the grant; a dropped valid lets it go.
          lock_next       = granted_valid && !m_membus.ready;
          lock_grant_next = grant;
        end
      end
      default: begin
        if (m_membus.rvalid) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      owner_reg      <= OWNER_I;
      last_grant_reg <= OWNER_D;
      lock_reg       <= 1'b0;
      lock_grant_reg <= OWNER_I;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      lock_reg       <= lock_next;
      lock_grant_reg <= lock_grant_next;
    end
  end
endmodule

// File: tb/tb_membus_arbiter.sv
// Directed checks of the memory-bus arbiter, round-robin and fixed-priority builds.
module tb_membus_arbiter;
  import eei::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  membus_if i_bus ();
  membus_if d_bus ();
  membus_if m_bus ();
  membus_if fi_bus ();
  membus_if fd_bus ();
  membus_if fm_bus ();

  membus_arbiter #(.RR_EN(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_membus(i_bus),
    .d_membus(d_bus),
    .m_membus(m_bus)
  );

  membus_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk     (clk),
    .rst     (rst),
    .i_membus(fi_bus),
    .d_membus(fd_bus),
    .m_membus(fm_bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    i_bus.valid = 0; i_bus.addr = 0; i_bus.wen = 0; i_bus.wdata = 0; i_bus.wmask = 0;
    d_bus.valid = 0; d_bus.addr = 0; d_bus.wen = 0; d_bus.wdata = 0; d_bus.wmask = 0;
    m_bus.ready = 0; m_bus.rvalid = 0; m_bus.rdata = 0;
    fi_bus.valid = 0; fi_bus.addr = 0; fi_bus.wen = 0; fi_bus.wdata = 0; fi_bus.wmask = 0;
    fd_bus.valid = 0; fd_bus.addr = 0; fd_bus.wen = 0; fd_bus.wdata = 0; fd_bus.wmask = 0;
    fm_bus.ready = 0; fm_bus.rvalid = 0; fm_bus.rdata = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rr_exp [4];
    rr_exp[0] = 32'h100; rr_exp[1] = 32'h200; rr_exp[2] = 32'h100; rr_exp[3] = 32'h200;

    // Reset: outputs quiet even with live inputs
    clear_all();
    i_bus.valid = 1; i_bus.addr = 32'h100; m_bus.ready = 1; m_bus.rvalid = 1;
    @(negedge clk);
    check("rst_i_ready", i_bus.ready, 0);
    check("rst_m_valid", m_bus.valid, 0);
    check("rst_i_rvalid", i_bus.rvalid, 0);
    check("rst_d_rvalid", d_bus.rvalid, 0);
    tick(); tick();
    rst = 1;
    clear_all();
    $display("txn reset released");

    // Round-robin ties: I, D, I, D
    i_bus.valid = 1; i_bus.addr = 32'h100;
    d_bus.valid = 1; d_bus.addr = 32'h200;
    m_bus.ready = 1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("rr_addr", m_bus.addr, rr_exp[n]);
      check("rr_ready", (rr_exp[n] == 32'h100) ? i_bus.ready : d_bus.ready, 1);
      tick();
      m_bus.rvalid = 1; m_bus.rdata = 32'hA0 + n;
      @(negedge clk);
      check("rr_wait_valid", m_bus.valid, 0);
      check("rr_rdata", (rr_exp[n] == 32'h100) ? i_bus.rdata : d_bus.rdata, 32'hA0 + n);
      check("rr_other_rvalid", (rr_exp[n] == 32'h100) ? d_bus.rvalid : i_bus.rvalid, 0);
      $display("txn rr %0d addr=0x%08h", n, rr_exp[n]);
      tick();
      m_bus.rvalid = 0;
    end

    // Grant lock: D stalled three cycles while I joins
    clear_all();
    d_bus.valid = 1; d_bus.addr = 32'h200;
    @(negedge clk);
    check("lk_c1_addr", m_bus.addr, 32'h200);
    check("lk_c1_valid", m_bus.valid, 1);
    check("lk_c1_dready", d_bus.ready, 0);
    tick();
    i_bus.valid = 1; i_bus.addr = 32'h100;
    @(negedge clk);
    check("lk_c2_addr", m_bus.addr, 32'h200);
    check("lk_c2_iready", i_bus.ready, 0);
    tick();
    @(negedge clk);
    check("lk_c3_addr", m_bus.addr, 32'h200);
    tick();
    m_bus.ready = 1;
    @(negedge clk);
    check("lk_c4_dready", d_bus.ready, 1);
    check("lk_c4_iready", i_bus.ready, 0);
    check("lk_c4_addr", m_bus.addr, 32'h200);
    tick();
    i_bus.valid = 0; d_bus.valid = 0;
    m_bus.rvalid = 1; m_bus.rdata = 32'h0BAD;
    @(negedge clk);
    check("lk_d_rvalid", d_bus.rvalid, 1);
    $display("txn lock D addr=0x00000200");
    tick();
    m_bus.rvalid = 0;

    // D write with a five-cycle response delay
    d_bus.valid = 1; d_bus.addr = 32'h300; d_bus.wen = 1;
    d_bus.wdata = 32'h55AA; d_bus.wmask = 4'hF;
    m_bus.ready = 1;
    @(negedge clk);
    check("wr_wen", m_bus.wen, 1);
    check("wr_wmask", m_bus.wmask, 4'hF);
    check("wr_wdata", m_bus.wdata, 32'h55AA);
    tick();
    d_bus.valid = 0; d_bus.wen = 0; d_bus.wmask = 0; d_bus.wdata = 0;
    i_bus.valid = 1; i_bus.addr = 32'h100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("wr_wait_iready", i_bus.ready, 0);
      check("wr_wait_dready", d_bus.ready, 0);
      check("wr_wait_mvalid", m_bus.valid, 0);
      tick();
    end
    m_bus.rvalid = 1; m_bus.rdata = 0;
    d_bus.valid = 1; d_bus.addr = 32'h200;
    @(negedge clk);
    check("wr_d_rvalid", d_bus.rvalid, 1);
    check("wr_rv_iready", i_bus.ready, 0);
    $display("txn write D addr=0x00000300");
    tick();
    m_bus.rvalid = 0;
    @(negedge clk);
    check("wr_next_iready", i_bus.ready, 1);
    check("wr_next_dready", d_bus.ready, 0);
    check("wr_next_addr", m_bus.addr, 32'h100);
    tick();
    i_bus.valid = 0; d_bus.valid = 0;
    m_bus.rvalid = 1; m_bus.rdata = 32'h77;
    @(negedge clk);
    check("wr_i_rdata", i_bus.rdata, 32'h77);
    $display("txn read I addr=0x00000100");
    tick();
    m_bus.rvalid = 0;

    // Lock released once the locked requester drops valid
    m_bus.ready = 0;
    d_bus.valid = 1;
    @(negedge clk);
    check("rel_c1_addr", m_bus.addr, 32'h200);
    tick();
    d_bus.valid = 0; i_bus.valid = 1;
    tick();
    @(negedge clk);
    check("rel_c3_addr", m_bus.addr, 32'h100);
    check("rel_c3_valid", m_bus.valid, 1);
    tick();
    i_bus.valid = 0;
    tick();
    $display("txn lock release");

    // Spurious response in IDLE
    m_bus.rvalid = 1; m_bus.rdata = 32'h1234;
    @(negedge clk);
    check("sp_i_rvalid", i_bus.rvalid, 0);
    check("sp_d_rvalid", d_bus.rvalid, 0);
    check("sp_i_rdata", i_bus.rdata, 0);
    check("sp_d_rdata", d_bus.rdata, 0);
    check("sp_m_valid", m_bus.valid, 0);
    check("sp_m_addr", m_bus.addr, 0);
    tick();
    m_bus.rvalid = 0;
    i_bus.valid = 1; m_bus.ready = 1;
    @(negedge clk);
    check("sp_after_iready", i_bus.ready, 1);
    $display("txn spurious rvalid");

    // Reset in WAIT abandons the response
    tick();
    i_bus.valid = 0;
    @(negedge clk);
    check("rs_wait_mvalid", m_bus.valid, 0);
    rst = 0;
    m_bus.rvalid = 1; m_bus.rdata = 32'hCAFE;
    #2;
    check("rs_i_rvalid", i_bus.rvalid, 0);
    check("rs_d_rvalid", d_bus.rvalid, 0);
    tick();
    rst = 1;
    @(negedge clk);
    check("rs_post_i_rvalid", i_bus.rvalid, 0);
    check("rs_post_d_rvalid", d_bus.rvalid, 0);
    check("rs_post_i_rdata", i_bus.rdata, 0);
    tick();
    m_bus.rvalid = 0;
    i_bus.valid = 1; i_bus.addr = 32'h100;
    d_bus.valid = 1; d_bus.addr = 32'h200;
    @(negedge clk);
    check("rs_tie_iready", i_bus.ready, 1);
    check("rs_tie_addr", m_bus.addr, 32'h100);
    $display("txn reset in WAIT");
    tick();
    clear_all();
    m_bus.rvalid = 1;
    tick();
    m_bus.rvalid = 0;

    // Fixed priority: D always wins ties
    fi_bus.valid = 1; fi_bus.addr = 32'h100;
    fd_bus.valid = 1; fd_bus.addr = 32'h200;
    fm_bus.ready = 1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("fp_addr", fm_bus.addr, 32'h200);
      check("fp_dready", fd_bus.ready, 1);
      check("fp_iready", fi_bus.ready, 0);
      tick();
      fm_bus.rvalid = 1; fm_bus.rdata = 32'hF0 + n;
      @(negedge clk);
      check("fp_d_rdata", fd_bus.rdata, 32'hF0 + n);
      $display("txn fp %0d addr=0x00000200", n);
      tick();
      fm_bus.rvalid = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/membus_arbiter.md
MEMBUS_ARBITER -- requirements
Module: membus_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning 1 selects round-robin and 0 selects fixed priority with the data port first.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock, rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port i_membus, membus_if.slave, the instruction-fetch requester.
REQ-005 The block SHALL have port d_membus, membus_if.slave, the load/store requester.
REQ-006 The block SHALL have port m_membus, membus_if.master, the shared bus into mmio_controller.
REQ-007 All three membus_if ports SHALL carry valid(1), ready(1), addr(Addr), wen(1), wdata(Data), wmask(Data/8), rvalid(1) and rdata(Data), with widths from eei.

Function
REQ-008 The FSM SHALL have two states: IDLE (nothing outstanding) and WAIT (one request accepted by m_membus, response pending).
REQ-009 In IDLE, the block SHALL select the granted requester and combinationally drive its addr/wen/wdata/wmask/valid onto m_membus.
REQ-010 In IDLE, granted.ready SHALL equal m_membus.ready, and non-granted.ready SHALL be 0.
REQ-011 With one requester valid, that requester SHALL be granted.
REQ-012 With both valid and RR_EN=1, the requester not in last_grant SHALL be granted.
REQ-013 With both valid and RR_EN=0, d_membus SHALL be granted.
REQ-014 Grant lock: if the granted valid=1 and m_membus.ready=0, grant SHALL be held by a lock register until the handshake, regardless of the other requester.
REQ-015 On handshake (m_membus.valid && m_membus.ready), the block SHALL register owner and last_grant, clear lock, and go to WAIT next cycle.
REQ-016 In WAIT, m_membus.valid SHALL be 0, and i_membus.ready and d_membus.ready SHALL both be 0.
REQ-017 In WAIT, owner.rvalid SHALL equal m_membus.rvalid and owner.rdata SHALL equal m_membus.rdata, combinationally with zero added latency.
REQ-018 Non-owner rvalid SHALL be 0 and non-owner rdata SHALL be 0 at all times.
REQ-019 WAIT with m_membus.rvalid=1 SHALL go to IDLE; the next grant SHALL occur no earlier than the following cycle, giving 2 cycles minimum per transaction.
REQ-020 m_membus.rvalid in IDLE SHALL be ignored, with no forwarding to any requester and no state change.
REQ-021 Write requests (wen=1) SHALL still wait for m_membus.rvalid before returning to IDLE.
REQ-022 When no requester is valid in IDLE, m_membus.valid SHALL be 0 and addr/wdata/wmask/wen SHALL be 0.
REQ-023 A requester dropping valid while locked but unaccepted SHALL release the lock in the next cycle.

Reset
REQ-024 On rst=0 the block SHALL asynchronously set state=IDLE, owner=I, last_grant=D (so I wins the first tie under RR), and lock=0.
REQ-025 During reset all ready, rvalid and m_membus.valid outputs SHALL be 0.
REQ-026 A reset in WAIT SHALL abandon the pending response; an rvalid arriving after reset release SHALL be ignored per REQ-020.

Structure
REQ-027 Package eei SHALL hold Addr, Data, the widths, and typedef enum membus_owner_t {OWNER_I, OWNER_D}.
REQ-028 The FSM state enum SHALL be local to the block.
REQ-029 Two-way grant logic (valids, last_grant, lock, RR_EN -> grant) SHALL be one sub-module, membus_rr_arb2.

Verification
REQ-030 Only I valid, addr=0x100, m_membus ready=1, rvalid next cycle with rdata=0xDEADBEEF -> i_membus.rvalid=1 with rdata=0xDEADBEEF; d_membus.rvalid=0.
REQ-031 Both valid every cycle with RR_EN=1 -> grants I, D, I, D over 4 transactions; with RR_EN=0 -> D, D, D, D.
REQ-032 D valid with m_membus.ready=0 for 3 cycles while I raises valid in cycle 2 -> D keeps the grant and its addr stays on the bus; D handshakes in cycle 4.
REQ-033 D write wen=1, wmask=0xF, rvalid delayed 5 cycles -> both ready=0 for 5 cycles; I is granted the cycle after rvalid.
REQ-034 Assert rst=0 in WAIT, release, then inject m_membus.rvalid=1 -> no requester rvalid; state=IDLE; next tie grants I.
REQ-035 Spurious m_membus.rvalid in IDLE with rdata=0x1234 -> both requester rvalid=0 and rdata=0.
